// File: rtl/norm_seq_ctrl.sv
// Sequencer for FP-add normalization: one 1-bit shift with exponent adjust per cycle until the value is normalized.
// Latency: 2 cycles from the accepted start to done, plus 1 cycle per left shift.
// Backpressure: none. start is sampled only in IDLE. Results and flags hold until the next accepted start.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start                   request; ignored while busy
//   exp_in, fraction_in     raw post-add exponent and 27-bit fraction ([26] carry, [25] hidden)
//   busy, done              operation in flight / one-cycle result-valid pulse
//   exp_out, fraction_out   normalized result, captured on entry to DONE
//   zero, overflow, underflow  mutually exclusive result status
//   shift, shift_src        datapath shift enable and direction (1 = right, exp+1)

// Single-step normalization datapath. Shifts the fraction by one bit and
// adjusts the exponent by one.
module norm_step (
  input  logic        right,
  input  logic [7:0]  exp_cur,
  input  logic [26:0] frac_cur,
  output logic [7:0]  exp_nxt,
  output logic [26:0] frac_nxt
);
  always_comb begin
    if (right) begin
      exp_nxt  = exp_cur + 8'd1;
      frac_nxt = {1'b0, frac_cur[26:1]};
    end else begin
      exp_nxt  = exp_cur - 8'd1;
      frac_nxt = {frac_cur[25:0], 1'b0};
    end
  end
endmodule

module norm_seq_ctrl #(
  parameter int MAX_STEPS = 26,
  parameter int EXP_MAX   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  exp_in,
  input  logic [26:0] fraction_in,
  output logic        busy,
  output logic        done,
  output logic [7:0]  exp_out,
  output logic [26:0] fraction_out,
  output logic        zero,
  output logic        overflow,
  output logic        underflow,
  output logic        shift,
  output logic        shift_src
);
  localparam int             CW       = $clog2(MAX_STEPS + 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(MAX_STEPS);
  localparam logic [7:0]     EXP_MAX8 = 8'(EXP_MAX);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t        state;
  logic [7:0]    exp_r;
  logic [26:0]   frac_r;
  logic [CW-1:0] step_cnt;
  logic [7:0]    exp_nxt;
  logic [26:0]   frac_nxt;

  norm_step u_step (
    .right    (shift_src),
    .exp_cur  (exp_r),
    .frac_cur (frac_r),
    .exp_nxt  (exp_nxt),
    .frac_nxt (frac_nxt)
  );

  // The shift request mirrors the SHIFT-state decision priority below. The
  // exponent guard keeps a left shift from taking the exponent below 1.
  always_comb begin
    shift     = 1'b0;
    shift_src = 1'b0;
    if (state == S_SHIFT && frac_r != '0) begin
      if (frac_r[26]) begin
        shift     = 1'b1;
        shift_src = 1'b1;
      end else if (!frac_r[25] && exp_r > 8'd1 && step_cnt != CNT_MAX) begin
        shift = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      exp_r        <= '0;
      frac_r       <= '0;
      step_cnt     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      exp_out      <= '0;
      fraction_out <= '0;
      zero         <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            exp_r     <= exp_in;
            frac_r    <= fraction_in;
            step_cnt  <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            busy      <= 1'b1;
            state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (frac_r == '0) begin
            // An exact zero gets a zero exponent regardless of the input exponent.
            zero         <= 1'b1;
            exp_r        <= '0;
            exp_out      <= '0;
            fraction_out <= '0;
            done         <= 1'b1;
            state        <= S_DONE;
          end else if (frac_r[26]) begin
            // The carry needs a single right shift. The post-shift value is
            // the result, so capture the datapath output directly.
            exp_r        <= exp_nxt;
            frac_r       <= frac_nxt;
            exp_out      <= exp_nxt;
            fraction_out <= frac_nxt;
            overflow     <= (exp_nxt == EXP_MAX8);
            done         <= 1'b1;
            state        <= S_DONE;
          end else if (frac_r[25] || exp_r <= 8'd1 || step_cnt == CNT_MAX) begin
            underflow    <= !frac_r[25] && exp_r <= 8'd1;
            exp_out      <= exp_r;
            fraction_out <= frac_r;
            done         <= 1'b1;
            state        <= S_DONE;
          end else begin
            exp_r    <= exp_nxt;
            frac_r   <= frac_nxt;
            step_cnt <= step_cnt + CW'(1);
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_norm_seq_ctrl.sv
// Randomized bench for norm_seq_ctrl. A transaction-level model expands each operation into per-cycle expectations.
// Latency: checks every cycle, 2 ns after each rising edge.
// Backpressure: none. Operations may hold start high through busy and may be aborted by reset.
module tb_norm_seq_ctrl;
  localparam int MAX_STEPS = 26;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  exp_in = '0;
  logic [26:0] fraction_in = '0;
  logic        busy, done, zero, overflow, underflow, shift, shift_src;
  logic [7:0]  exp_out;
  logic [26:0] fraction_out;

  int checks = 0;
  int errors = 0;

  norm_seq_ctrl #(.MAX_STEPS(MAX_STEPS), .EXP_MAX(255)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .exp_in       (exp_in),
    .fraction_in  (fraction_in),
    .busy         (busy),
    .done         (done),
    .exp_out      (exp_out),
    .fraction_out (fraction_out),
    .zero         (zero),
    .overflow     (overflow),
    .underflow    (underflow),
    .shift        (shift),
    .shift_src    (shift_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  e;
    logic [26:0] f;
    bit          z, o, u, right;
    int          k;
  } res_t;

  typedef struct {
    bit          busy, done, shift, src, zero, ovf, unf;
    logic [7:0]  e;
    logic [26:0] f;
  } exp_t;

  exp_t q[$];
  exp_t idle_exp = '{default: 0};
  int   skip_to = 0;

  // Normalization rules applied directly to the numbers.
  function automatic res_t model(input logic [7:0] e_in, input logic [26:0] f_in);
    res_t        r;
    int          e;
    logic [26:0] f;
    r = '{default: 0};
    e = int'(e_in);
    f = f_in;
    if (f == 0) begin
      r.z = 1;
      e   = 0;
    end else if (f[26]) begin
      f       = f >> 1;
      e       = e + 1;
      r.right = 1;
      r.o     = (e == 255);
    end else begin
      while (!f[25]) begin
        if (e <= 1) begin
          r.u = 1;
          break;
        end
        if (r.k == MAX_STEPS) break;
        f   = f << 1;
        e   = e - 1;
        r.k = r.k + 1;
      end
    end
    r.e = 8'(e);
    r.f = f;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Compare process: the model is pinned first, then the DUT is checked every cycle.
  initial begin
    res_t r;
    exp_t x;
    int   rd;
    rd = 0;
    r = model(8'd127, 27'h2000000);
    chk("pin_norm_e", r.e, 127);  chk("pin_norm_k", r.k, 0);
    r = model(8'd127, 27'h4000002);
    chk("pin_right_e", r.e, 128); chk("pin_right_f", r.f, 32'h2000001);
    r = model(8'd130, 27'h0000100);
    chk("pin_left_k", r.k, 17);   chk("pin_left_lat", r.k + 2, 19);
    chk("pin_left_e", r.e, 113);  chk("pin_left_f", r.f, 32'h2000000);
    r = model(8'd90, 27'h0);
    chk("pin_zero", r.z, 1);      chk("pin_zero_e", r.e, 0);
    r = model(8'd254, 27'h4000000);
    chk("pin_ovf", r.o, 1);       chk("pin_ovf_e", r.e, 255);
    r = model(8'd3, 27'h0100000);
    chk("pin_unf", r.u, 1);       chk("pin_unf_k", r.k, 2);
    chk("pin_unf_e", r.e, 1);     chk("pin_unf_f", r.f, 32'h0400000);
    forever begin
      @(posedge clk);
      #2;
      if (rd < skip_to) rd = skip_to;
      if (rd < q.size()) begin
        x  = q[rd];
        rd = rd + 1;
      end else begin
        x = idle_exp;
      end
      chk("busy", busy, x.busy);
      chk("done", done, x.done);
      chk("shift", shift, x.shift);
      chk("shift_src", shift_src, x.src);
      chk("zero", zero, x.zero);
      chk("overflow", overflow, x.ovf);
      chk("underflow", underflow, x.unf);
      chk("exp_out", exp_out, x.e);
      chk("fraction_out", fraction_out, x.f);
    end
  end

  // One operation. With hold set, start stays high through busy with junk
  // inputs. abort_at > 0 pulses reset in that cycle after acceptance.
  task automatic run_op(input logic [7:0] e, input logic [26:0] f, input bit hold, input int abort_at);
    res_t r;
    exp_t x;
    int   lat;
    @(negedge clk);
    assert (!(f[26] && e == 8'hFF))
      else $fatal(1, "FAIL stimulus: carry-set fraction with exponent 255");
    r   = model(e, f);
    lat = r.k + 2;
    start = 1'b1;
    exp_in = e;
    fraction_in = f;
    for (int c = 1; c <= lat; c++) begin
      x.busy  = 1;
      x.done  = (c == lat);
      x.shift = r.right ? (c == 1) : (c <= r.k);
      x.src   = r.right && (c == 1);
      if (c == lat) begin
        x.zero = r.z; x.ovf = r.o; x.unf = r.u; x.e = r.e; x.f = r.f;
      end else begin
        x.zero = 0; x.ovf = 0; x.unf = 0; x.e = idle_exp.e; x.f = idle_exp.f;
      end
      q.push_back(x);
    end
    idle_exp = x;
    idle_exp.busy = 0; idle_exp.done = 0; idle_exp.shift = 0; idle_exp.src = 0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (abort_at == c) begin
        rst_n    = 1'b0;
        start    = 1'b0;
        skip_to  = q.size();
        idle_exp = '{default: 0};
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      start = hold;
      if (hold) begin
        exp_in      = 8'($urandom);
        fraction_in = 27'($urandom);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    logic [7:0]  e;
    logic [26:0] f;
    int          cls, pos, ab;
    res_t        r;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    run_op(8'd127, 27'h2000000, 0, 0);  idle(1);
    run_op(8'd127, 27'h4000002, 0, 0);  idle(1);
    run_op(8'd130, 27'h0000100, 0, 0);  idle(1);
    run_op(8'd90,  27'h0000000, 0, 0);
    run_op(8'd254, 27'h4000000, 0, 0);  idle(1);
    run_op(8'd3,   27'h0100000, 0, 0);  idle(1);
    run_op(8'd130, 27'h0000100, 1, 8);  idle(1);
    run_op(8'd130, 27'h0000100, 1, 0);  idle(1);
    run_op(8'd0,   27'h0000001, 0, 0);
    run_op(8'd26,  27'h0000001, 0, 0);
    run_op(8'd200, 27'h0000001, 0, 0);  idle(1);

    for (int n = 0; n < 300; n++) begin
      cls = $urandom_range(0, 9);
      e   = 8'($urandom_range(0, 255));
      if (cls == 0) begin
        f = '0;
      end else if (cls == 1) begin
        f = {1'b1, 26'($urandom)};
        if (e == 8'hFF) e = 8'hFE;
      end else begin
        pos = $urandom_range(0, 25);
        f   = (27'd1 << pos) | (27'($urandom) & ((27'd1 << pos) - 27'd1));
        if (cls == 2) e = 8'($urandom_range(0, 30));
      end
      r  = model(e, f);
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(1, r.k + 2) : 0;
      run_op(e, f, bit'($urandom_range(0, 1)), ab);
      idle($urandom_range(0, 2));
    end

    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
